// File: rtl/aes_key_sched_ctrl.sv
// rtl/aes_key_sched_ctrl.sv - AES key-expansion sequencer and round-key server for two round engines
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   cfg_valid/cfg_ready      key offer handshake; cfg_nk (4/6/8 words), cfg_key (left-justified)
//   kx_rst, kx_nk, kx_key    expander control: active-high reset and registered key/Nk
//   kx_done, kx_w            expander completion and expanded schedule (word k at [32k+31:32k])
//   req_valid, req_round     per-requester round-key request, round i at [4i+3:4i]
//   gnt                      one-hot combinational grant while READY
//   rk_valid, rk_id,
//   rk_data, rk_err          registered round-key response one cycle after grant
//   key_ready, err, nr       schedule valid, bad Nk/timeout, rounds (Nk+6) of current key
module aes_key_sched_ctrl #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 96
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [3:0]             cfg_nk,
    input  logic [255:0]           cfg_key,
    output logic                   kx_rst,
    output logic [3:0]             kx_nk,
    output logic [255:0]           kx_key,
    input  logic                   kx_done,
    input  logic [1919:0]          kx_w,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [4*NUM_REQ-1:0]   req_round,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   rk_valid,
    output logic                   rk_id,
    output logic [127:0]           rk_data,
    output logic                   rk_err,
    output logic                   key_ready,
    output logic                   err,
    output logic [3:0]             nr
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST     = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] KXRST_LAST = TW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KXRST,
        S_EXPAND,
        S_READY,
        S_ERROR
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [TW-1:0]   timer;
    logic            rr_ptr;
    logic            accept;
    logic            nk_ok;
    logic [3:0]      sel_round;
    logic [2047:0]   w_ext;
    logic [10:0]     blk_lsb;
    logic [127:0]    blk;

    assign accept = cfg_valid & cfg_ready;
    assign nk_ok  = (cfg_nk == 4'd4) || (cfg_nk == 4'd6) || (cfg_nk == 4'd8);

    // Pad the schedule so rounds above 14 index harmlessly; those are rejected anyway.
    assign w_ext     = {128'b0, kx_w};
    assign sel_round = gnt[1] ? req_round[7:4] : req_round[3:0];
    assign blk_lsb   = {sel_round, 7'd0};
    assign blk       = w_ext[blk_lsb +: 128];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_READY, S_ERROR: begin
                if (accept) begin
                    state_nxt = nk_ok ? S_KXRST : S_ERROR;
                end
            end
            S_KXRST: begin
                if (timer == KXRST_LAST) begin
                    state_nxt = S_EXPAND;
                end
            end
            S_EXPAND: begin
                if (kx_done) begin
                    state_nxt = S_READY;
                end else if (timer == T_LAST) begin
                    state_nxt = S_ERROR;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs and arbitration
    always_comb begin
        cfg_ready = 1'b0;
        kx_rst    = 1'b1;
        key_ready = 1'b0;
        err       = 1'b0;
        gnt       = '0;
        case (state)
            S_IDLE:   cfg_ready = 1'b1;
            S_KXRST:  kx_rst = 1'b1;
            S_EXPAND: kx_rst = 1'b0;
            S_READY: begin
                cfg_ready = 1'b1;
                kx_rst    = 1'b0;
                key_ready = 1'b1;
                // A new key being accepted invalidates the schedule this cycle.
                if (!accept) begin
                    case (req_valid)
                        2'b01:   gnt = 2'b01;
                        2'b10:   gnt = 2'b10;
                        2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
                        default: gnt = 2'b00;
                    endcase
                end
            end
            S_ERROR: begin
                cfg_ready = 1'b1;
                err       = 1'b1;
            end
            default: cfg_ready = 1'b0;
        endcase
    end

    // Shared counter: KXRST pulse length, then EXPAND watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timer <= '0;
        end else if (accept) begin
            timer <= '0;
        end else begin
            case (state)
                S_KXRST:  timer <= (timer == KXRST_LAST) ? '0 : timer + TW'(1);
                S_EXPAND: timer <= timer + TW'(1);
                default:  timer <= '0;
            endcase
        end
    end

    // Configuration capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            kx_key <= '0;
            kx_nk  <= '0;
            nr     <= '0;
        end else if (accept) begin
            kx_key <= cfg_key;
            kx_nk  <= cfg_nk;
            nr     <= nk_ok ? cfg_nk + 4'd6 : 4'd0;
        end
    end

    // Round-robin pointer moves only when both requesters contended.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= 1'b0;
        end else if ((&req_valid) && (|gnt)) begin
            rr_ptr <= gnt[0];
        end
    end

    // Round-key response; word 4r sits in the low bits of blk but goes to the top of rk_data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rk_valid <= 1'b0;
            rk_id    <= 1'b0;
            rk_data  <= '0;
            rk_err   <= 1'b0;
        end else begin
            rk_valid <= |gnt;
            rk_id    <= gnt[1];
            if ((|gnt) && (sel_round <= nr)) begin
                rk_data <= {blk[31:0], blk[63:32], blk[95:64], blk[127:96]};
                rk_err  <= 1'b0;
            end else if (|gnt) begin
                rk_data <= '0;
                rk_err  <= 1'b1;
            end else begin
                rk_data <= '0;
                rk_err  <= 1'b0;
            end
        end
    end

endmodule
